// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// load-size encodings (same as data_mem), register offsets within the
// 16-byte window, STATUS bit positions, the serial engine state enum and
// the load-extension helper.
package mmio_uart_tx_pkg;

    // MemOp encodings for loads
    localparam logic [2:0] MEMOP_W  = 3'b000;  // word
    localparam logic [2:0] MEMOP_HS = 3'b001;  // half, sign-extended
    localparam logic [2:0] MEMOP_BS = 3'b010;  // byte, sign-extended
    localparam logic [2:0] MEMOP_HU = 3'b101;  // half, zero-extended
    localparam logic [2:0] MEMOP_BU = 3'b110;  // byte, zero-extended

    // Register index = addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Narrow a register value to the load size and extend it, taking the
    // low bits of the register. Unknown encodings return the full word.
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] v);
        logic [31:0] r;
        case (op)
            MEMOP_HS: r = {{16{v[15]}}, v[15:0]};
            MEMOP_BS: r = {{24{v[7]}}, v[7:0]};
            MEMOP_HU: r = {16'h0000, v[15:0]};
            MEMOP_BU: r = {24'h000000, v[7:0]};
            default:  r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO used as the UART TX byte queue.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data write request and data; ignored when full unless a pop
//                  happens on the same edge
//   i_pop          read request; ignored when empty
//   o_data         current head entry (valid when !o_empty)
//   o_full/o_empty status flags
//   o_count        occupancy, reports DEPTH when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A pop on the same edge frees the slot, so a push into a full FIFO
    // is accepted in that case.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the CPU data-memory bus
// beside data_mem. Stores to TXDATA queue bytes; the serial engine drains
// the queue onto txd. The enclosing top muxes loads as
// sel ? this.dout : data_mem.dout and gates data_mem's write enable by !sel.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   addr      byte address; window BASE..BASE+15 decoded on addr[31:4]
//   din       store data
//   MemOp     load size/extension (ignored for stores)
//   MemWr     store strobe
//   dout      load data, 0 outside the window
//   sel       address is inside the window
//   txd       serial output, idle high
//   irq       high when the queue is empty and the engine is idle
// Registers (addr[3:2]): 0 TXDATA (W push, R 0), 1 STATUS, 2 DIV, 3 reserved.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h1000_0000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  MemOp,
    input  logic        MemWr,
    output logic [31:0] dout,
    output logic        sel,
    output logic        txd,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Bus decode
    logic        w_sel;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_push;
    logic        w_unused;

    assign w_sel    = (addr[31:4] == BASE[31:4]);
    assign w_reg    = addr[3:2];
    assign w_wr     = w_sel && MemWr;
    assign w_push   = w_wr && (w_reg == REG_TXDATA);
    assign w_unused = ^{addr[1:0], din[31:16]};

    // FIFO
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (din[7:0]),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Configuration / sticky status
    logic [15:0] r_div;
    logic        r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_DEFAULT;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_DIV)) begin
                // A zero divisor would never finish a bit; clamp to 1.
                r_div <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_reg == REG_STATUS) && din[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serial engine
    tx_state_t   r_state, w_state_nxt;
    logic [15:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [15:0] r_div_lat, w_div_lat_nxt;
    logic        w_baud_end;
    logic        w_txd;

    assign w_baud_end = (r_baud == (r_div_lat - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_lat <= DIV_DEFAULT;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_div_lat <= w_div_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_div_lat_nxt = r_div_lat;
        w_pop         = 1'b0;
        w_txd         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_baud_nxt    = '0;
                    w_div_lat_nxt = r_div;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                w_txd = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            ST_DATA: begin
                w_txd = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next frame when data waits.
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_head;
                        w_div_lat_nxt = r_div;
                        w_state_nxt   = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign txd = w_txd;
    assign irq = w_empty && (r_state == ST_IDLE);
    assign sel = w_sel;

    // Load path
    logic [31:0] w_status;
    logic [31:0] w_reg_val;

    always_comb begin
        w_status              = 32'(w_count) << STAT_CNT_LSB;
        w_status[STAT_BUSY]   = (r_state != ST_IDLE);
        w_status[STAT_FULL]   = w_full;
        w_status[STAT_EMPTY]  = w_empty;
        w_status[STAT_OVF]    = r_ovf;
    end

    always_comb begin
        w_reg_val = '0;
        case (w_reg)
            REG_TXDATA: w_reg_val = '0;
            REG_STATUS: w_reg_val = w_status;
            REG_DIV:    w_reg_val = {16'h0000, r_div};
            REG_RSVD:   w_reg_val = '0;
            default:    w_reg_val = '0;
        endcase
    end

    assign dout = w_sel ? load_extend(MemOp, w_reg_val) : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;
    logic [2:0]  MemOp = 3'b000;
    logic        MemWr = 1'b0;
    logic [31:0] dout;
    logic        sel;
    logic        txd;
    logic        irq;

    mmio_uart_tx dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .MemOp (MemOp),
        .MemWr (MemWr),
        .dout  (dout),
        .sel   (sel),
        .txd   (txd),
        .irq   (irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         tb_div = 868;
    bit         mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        @(negedge clk);
        addr = a; din = d; MemOp = op; MemWr = 1'b1;
        @(negedge clk);
        MemWr = 1'b0; addr = 32'h0; din = 32'h0; MemOp = MEMOP_W;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [2:0] op,
                          output logic [31:0] d, output logic s);
        @(negedge clk);
        addr = a; MemOp = op; MemWr = 1'b0;
        #1;
        d = dout;
        s = sel;
    endtask

    // ---------------- frame monitor / scoreboard ----------------
    initial begin : monitor
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd === 1'b0) begin
                int d;
                d = tb_div;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = txd;
                end
                repeat (d) @(negedge clk);
                stop_bit = txd;
                if (mon_en) begin
                    check("frame_stop", 32'(stop_bit), 32'h1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL frame_unexpected: got byte %02h expected no frame", b);
                    end else begin
                        check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr_en;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rd_addr;
        logic [2:0]  op;
        logic [31:0] exp_dout;
        logic        exp_sel;
    } vec_t;

    vec_t        vecs[17];
    logic [31:0] rd;
    logic        rs;

    initial begin : main
        logic [7:0] bv;
        logic [7:0] b3[3];
        logic [7:0] bc;
        logic       e;
        int         t;
        int         lows;

        vecs[0]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h0,  MEMOP_W,  32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h4,  MEMOP_W,  32'h0000_0004, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  MEMOP_W,  32'h0000_0364, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  MEMOP_BS, 32'h0000_0064, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'hC,  MEMOP_W,  32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h10, MEMOP_W,  32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, BASE + 32'h8,  32'h0000_80F0, BASE + 32'h8,  MEMOP_HS, 32'hFFFF_80F0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  MEMOP_BS, 32'hFFFF_FFF0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  MEMOP_BU, 32'h0000_00F0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  MEMOP_HU, 32'h0000_80F0, 1'b1};
        vecs[10] = '{1'b1, BASE + 32'h8,  32'h0000_8000, BASE + 32'h8,  MEMOP_HS, 32'hFFFF_8000, 1'b1};
        vecs[11] = '{1'b1, BASE + 32'h8,  32'h0000_0000, BASE + 32'h8,  MEMOP_W,  32'h0000_0001, 1'b1};
        vecs[12] = '{1'b1, BASE + 32'h10, 32'h0000_1234, BASE + 32'h8,  MEMOP_W,  32'h0000_0001, 1'b1};
        vecs[13] = '{1'b0, 32'h0,         32'h0,         BASE + 32'h4,  MEMOP_W,  32'h0000_0004, 1'b1};
        vecs[14] = '{1'b1, BASE + 32'hC,  32'h0000_FFFF, BASE + 32'h8,  MEMOP_W,  32'h0000_0001, 1'b1};
        vecs[15] = '{1'b1, BASE + 32'h18, 32'h0000_0005, BASE + 32'h8,  MEMOP_W,  32'h0000_0001, 1'b1};
        vecs[16] = '{1'b1, BASE + 32'h8,  32'hABCD_0004, BASE + 32'h8,  MEMOP_BS, 32'h0000_0004, 1'b1};

        // ---- reset ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_irq", 32'(irq), 32'h1);
        check("reset_sel_outside", 32'(sel), 32'h0);
        check("reset_dout_outside", dout, 32'h0);

        // ---- register table ----
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr_en) bus_wr(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].op);
            bus_rd(vecs[i].rd_addr, vecs[i].op, rd, rs);
            check($sformatf("vec%0d_dout", i), rd, vecs[i].exp_dout);
            check($sformatf("vec%0d_sel", i), 32'(rs), 32'(vecs[i].exp_sel));
        end
        tb_div = 4;

        // ---- single 0x55 frame, DIV=4, exact waveform ----
        bv = 8'h55;
        exp_q.push_back(bv);
        bus_wr(BASE, 32'(bv), MEMOP_W);
        check("a_txd_push_edge", 32'(txd), 32'h1);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j < 4)       e = 1'b0;
            else if (j < 36) e = bv[(j - 4) / 4];
            else             e = 1'b1;
            check($sformatf("a_txd_%0d", j), 32'(txd), 32'(e));
            if (j == 0) check("a_irq_busy", 32'(irq), 32'h0);
        end
        @(negedge clk);
        check("a_irq_end", 32'(irq), 32'h1);
        check("a_txd_end", 32'(txd), 32'h1);

        // ---- three back-to-back frames, DIV=2 ----
        bus_wr(BASE + 32'h8, 32'd2, MEMOP_W);
        tb_div = 2;
        b3[0] = 8'hA5; b3[1] = 8'h3C; b3[2] = 8'hF0;
        @(negedge clk);
        addr = BASE; MemOp = MEMOP_W; MemWr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 32'(b3[i]);
            exp_q.push_back(b3[i]);
            @(negedge clk);
        end
        MemWr = 1'b0; addr = BASE + 32'h4; din = 32'h0;
        for (int j = 0; j < 59; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            check($sformatf("b_busy_%0d", j), 32'(dout[STAT_BUSY]), 32'h1);
            check($sformatf("b_irq_%0d", j), 32'(irq), 32'h0);
        end
        @(negedge clk);
        #1;
        check("b_busy_end", 32'(dout[STAT_BUSY]), 32'h0);
        check("b_irq_end", 32'(irq), 32'h1);

        // ---- overflow, DIV=1: 12 pushes in 12 cycles ----
        bus_wr(BASE + 32'h8, 32'd1, MEMOP_W);
        tb_div = 1;
        @(negedge clk);
        addr = BASE; MemOp = MEMOP_W; MemWr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bc = 8'(i * 17 + 3);
            din = 32'(bc);
            // 10th and 11th land on a full FIFO; the 12th meets a pop.
            if (i < 9 || i == 11) exp_q.push_back(bc);
            @(negedge clk);
        end
        MemWr = 1'b0; addr = BASE + 32'h4; din = 32'h0;
        #1;
        check("c_status_full", dout, 32'h0000_080B);
        bus_rd(BASE + 32'h4, MEMOP_BS, rd, rs);
        check("c_status_byte", rd, 32'h0000_000B);
        bus_wr(BASE + 32'h4, 32'h8, MEMOP_W);
        bus_rd(BASE + 32'h4, MEMOP_W, rd, rs);
        check("c_status_ovf_clr", rd, 32'h0000_0803);
        t = 0;
        while (!irq && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("c_drain_irq", 32'(irq), 32'h1);
        repeat (2) @(negedge clk);
        check("c_queue_empty", 32'(exp_q.size()), 32'h0);

        // ---- reset during DATA bit 3, DIV=4 ----
        bus_wr(BASE + 32'h8, 32'd4, MEMOP_W);
        tb_div = 4;
        mon_en = 1'b0;
        @(negedge clk);
        addr = BASE; MemOp = MEMOP_W; MemWr = 1'b1; din = 32'h0;
        @(negedge clk);
        din = 32'h11;
        @(negedge clk);
        MemWr = 1'b0; addr = 32'h0; din = 32'h0;
        repeat (17) @(negedge clk);
        check("d_txd_bit3", 32'(txd), 32'h0);
        check("d_irq_busy", 32'(irq), 32'h0);
        rst = 1'b1;
        addr = BASE; din = 32'h77; MemWr = 1'b1;
        @(negedge clk);
        MemWr = 1'b0; addr = BASE + 32'h4; din = 32'h0;
        #1;
        check("d_txd_after_rst", 32'(txd), 32'h1);
        check("d_status_after_rst", dout, 32'h0000_0004);
        check("d_irq_after_rst", 32'(irq), 32'h1);
        rst = 1'b0;
        bus_rd(BASE + 32'h8, MEMOP_W, rd, rs);
        check("d_div_after_rst", rd, 32'h0000_0364);
        lows = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("d_txd_idle_lows", 32'(lows), 32'h0);
        bus_rd(BASE + 32'h4, MEMOP_W, rd, rs);
        check("d_status_idle", rd, 32'h0000_0004);
        mon_en = 1'b1;

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
